// File: rtl/seg_shift_driver_if.sv
// Result handshake between calculator_core and the seven-segment display back end.
// The upstream side drives data/error/valid and the display side answers with ready.
interface seg_shift_driver_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_error;
   logic                  i_valid;
   logic                  o_ready;

   modport master (
      output i_data,
      output i_error,
      output i_valid,
      input  o_ready
   );

   modport slave (
      input  i_data,
      input  i_error,
      input  i_valid,
      output o_ready
   );
endinterface

// File: rtl/seg_shift_driver.sv
// Display back end of the calculator. It takes one signed result (or an error flag) per
// handshake, converts the magnitude to BCD with a sequential double-dabble, encodes one
// seven-segment byte per digit, and shifts the bytes serially into a chain of
// 74HC595-style registers. The data, clock and latch pins are all registered. Each pin
// therefore shows the state of the previous cycle.
module seg_shift_driver #(
   parameter int DATA_WIDTH         = 16,
   parameter int NUM_7_SEG_DISPLAYS = 5
) (
   input  logic               clk,
   input  logic               rst,
   seg_shift_driver_if.slave  bus,
   output logic               o_ser_data,
   output logic               o_ser_clk,
   output logic               o_ser_latch
);

   localparam int BCD_W        = 4 * NUM_7_SEG_DISPLAYS;
   localparam int FRAME_W      = 8 * NUM_7_SEG_DISPLAYS;
   localparam int SHIFT_CYCLES = 16 * NUM_7_SEG_DISPLAYS;
   localparam int CNT_MAX      = (SHIFT_CYCLES > DATA_WIDTH) ? SHIFT_CYCLES : DATA_WIDTH;
   localparam int CNT_W        = $clog2(CNT_MAX);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CONVERT = 3'd1,
      ENCODE  = 3'd2,
      SHIFT   = 3'd3,
      LATCH   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_WIDTH-1:0] mag_q, mag_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic [BCD_W-1:0]     bcd_adj;
   logic                 sign_q, sign_d;
   logic                 err_q, err_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic [FRAME_W-1:0]   frame_enc;
   logic                 ready_q, ready_d;
   logic                 ser_data_q, ser_data_d;
   logic                 ser_clk_q, ser_clk_d;
   logic                 ser_latch_q, ser_latch_d;
   logic                 accept;
   logic                 seen_nonzero;
   logic [3:0]           digit;

   // Segment pattern {dp,g,f,e,d,c,b,a}. Codes above 9 never occur after conversion.
   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'h3F;
         4'd1:    s = 8'h06;
         4'd2:    s = 8'h5B;
         4'd3:    s = 8'h4F;
         4'd4:    s = 8'h66;
         4'd5:    s = 8'h6D;
         4'd6:    s = 8'h7D;
         4'd7:    s = 8'h07;
         4'd8:    s = 8'h7F;
         4'd9:    s = 8'h6F;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   assign bus.o_ready  = ready_q;
   assign o_ser_data   = ser_data_q;
   assign o_ser_clk    = ser_clk_q;
   assign o_ser_latch  = ser_latch_q;

   // A transfer happens only while idle, and only when ready was already shown upstream.
   assign accept = (state_q == IDLE) && ready_q && bus.i_valid;

   // Double-dabble correction: add 3 to every BCD nibble of 5 or more before the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < NUM_7_SEG_DISPLAYS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end
   end

   // Frame encoder. It blanks leading zeros but never the rightmost digit. The sign is
   // shown as the dp of the leftmost byte. The error pattern replaces the digits.
   always_comb begin
      frame_enc    = '0;
      seen_nonzero = 1'b0;
      digit        = '0;
      if (err_q) begin
         frame_enc[23:0] = {8'h79, 8'h50, 8'h50};
      end else begin
         for (int k = NUM_7_SEG_DISPLAYS - 1; k >= 0; k--) begin
            digit = bcd_q[4*k +: 4];
            if (digit != 4'd0) begin
               seen_nonzero = 1'b1;
            end
            if (seen_nonzero || (k == 0)) begin
               frame_enc[8*k +: 8] = seg7(digit);
            end
         end
         if (sign_q) begin
            frame_enc[FRAME_W-1] = 1'b1;
         end
      end
   end

   // Next-state logic and next values of every register and output pin.
   always_comb begin
      state_d     = state_q;
      mag_d       = mag_q;
      bcd_d       = bcd_q;
      sign_d      = sign_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      frame_d     = frame_q;
      ready_d     = 1'b0;
      ser_data_d  = 1'b0;
      ser_clk_d   = 1'b0;
      ser_latch_d = 1'b0;

      case (state_q)
         IDLE: begin
            ready_d = !accept;
            if (accept) begin
               sign_d = bus.i_data[DATA_WIDTH-1];
               mag_d  = bus.i_data[DATA_WIDTH-1] ? (~bus.i_data + DATA_WIDTH'(1)) : bus.i_data;
               err_d  = bus.i_error;
               bcd_d  = '0;
               cnt_d  = '0;
               state_d = bus.i_error ? ENCODE : CONVERT;
            end
         end

         CONVERT: begin
            bcd_d = {bcd_adj[BCD_W-2:0], mag_q[DATA_WIDTH-1]};
            mag_d = {mag_q[DATA_WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = ENCODE;
            end
         end

         ENCODE: begin
            frame_d = frame_enc;
            cnt_d   = '0;
            state_d = SHIFT;
         end

         SHIFT: begin
            ser_data_d = frame_q[FRAME_W-1];
            ser_clk_d  = cnt_q[0];
            if (cnt_q[0]) begin
               frame_d = {frame_q[FRAME_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SHIFT_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = LATCH;
            end
         end

         LATCH: begin
            ser_latch_d = 1'b1;
            state_d     = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset clears everything, and an aborted frame is never latched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mag_q       <= '0;
         bcd_q       <= '0;
         sign_q      <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         frame_q     <= '0;
         ready_q     <= 1'b0;
         ser_data_q  <= 1'b0;
         ser_clk_q   <= 1'b0;
         ser_latch_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mag_q       <= mag_d;
         bcd_q       <= bcd_d;
         sign_q      <= sign_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         frame_q     <= frame_d;
         ready_q     <= ready_d;
         ser_data_q  <= ser_data_d;
         ser_clk_q   <= ser_clk_d;
         ser_latch_q <= ser_latch_d;
      end
   end

endmodule

// File: tb/tb_seg_shift_driver.sv
// Directed testbench for seg_shift_driver. A model of the shift-register chain
// rebuilds each latched frame. The bench checks the frame, the latch and ready
// timing, the number of shift-clock edges, and the mid-frame reset.
module tb_seg_shift_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ser_data;
   logic ser_clk;
   logic ser_latch;

   int checks = 0;
   int errors = 0;

   int          edges       = 0;
   logic [39:0] shreg       = '0;
   int          latch_count = 0;

   typedef struct {
      string       name;
      logic [15:0] data;
      logic        err;
      logic [39:0] frame;
      int          latency;
   } vec_t;

   vec_t vecs[10];

   seg_shift_driver_if #(.DATA_WIDTH(16)) bus ();

   seg_shift_driver #(
      .DATA_WIDTH(16),
      .NUM_7_SEG_DISPLAYS(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .o_ser_data(ser_data),
      .o_ser_clk(ser_clk),
      .o_ser_latch(ser_latch)
   );

   // 100 MHz system clock
   always #5 clk = ~clk;

   // Model of the external 74HC595 chain: sample data on every rising shift clock
   always @(posedge ser_clk) begin
      shreg <= {shreg[38:0], ser_data};
      edges <= edges + 1;
   end

   // Count latch pulses so that an aborted frame can be shown never to latch
   always @(negedge clk) begin
      if (ser_latch) latch_count <= latch_count + 1;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Wait for ready at a negedge, then offer one value. Return at the negedge of the accept cycle.
   task automatic applyStimulus(input logic [15:0] data, input logic err, input bit keep_valid);
      int waited = 0;
      @(negedge clk);
      while (!bus.o_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("ready_before_accept", {63'd0, bus.o_ready}, 64'd1);
      bus.i_data  = data;
      bus.i_error = err;
      bus.i_valid = 1'b1;
      @(negedge clk);
      if (!keep_valid) bus.i_valid = 1'b0;
   endtask

   // Count negedges from the accept cycle (k=0) up to the latch pulse. Also count cycles that showed ready while busy.
   task automatic waitLatch(output int lat, output int busy_ready);
      lat = -1;
      busy_ready = 0;
      for (int k = 0; k < 300; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.o_ready) busy_ready++;
         if (ser_latch) begin
            lat = k;
            break;
         end
      end
   endtask

   // Run one full frame and compare it with its table entry
   task automatic runVector(input vec_t v);
      int base;
      int lat;
      int busy;
      base = edges;
      applyStimulus(v.data, v.err, 1'b0);
      waitLatch(lat, busy);
      checkOutput({v.name, "_latency"}, 64'(lat), 64'(v.latency));
      checkOutput({v.name, "_frame"}, {24'd0, shreg}, {24'd0, v.frame});
      checkOutput({v.name, "_edges"}, 64'(edges - base), 64'd40);
      checkOutput({v.name, "_busy_ready"}, 64'(busy), 64'd0);
      @(negedge clk);
      checkOutput({v.name, "_ready_after"}, {63'd0, bus.o_ready}, 64'd1);
      checkOutput({v.name, "_latch_width"}, {63'd0, ser_latch}, 64'd0);
   endtask

   initial begin
      int lat;
      int busy;
      int base;
      int lc_before;
      vec_t v42;

      vecs[0] = '{"v1234",   16'd1234, 1'b0, 40'h00_06_5B_4F_66, 98};
      vecs[1] = '{"vneg5",   16'hFFFB, 1'b0, 40'h80_00_00_00_6D, 98};
      vecs[2] = '{"vmin",    16'h8000, 1'b0, 40'hCF_5B_07_7D_7F, 98};
      vecs[3] = '{"vzero",   16'h0000, 1'b0, 40'h00_00_00_00_3F, 98};
      vecs[4] = '{"verr",    16'd1234, 1'b1, 40'h00_00_79_50_50, 82};
      vecs[5] = '{"vmax",    16'h7FFF, 1'b0, 40'h4F_5B_07_7D_07, 98};
      vecs[6] = '{"v100",    16'd100,  1'b0, 40'h00_00_06_3F_3F, 98};
      vecs[7] = '{"vneg1",   16'hFFFF, 1'b0, 40'h80_00_00_00_06, 98};
      vecs[8] = '{"verrneg", 16'hFFFB, 1'b1, 40'h00_00_79_50_50, 82};
      vecs[9] = '{"v9",      16'd9,    1'b0, 40'h00_00_00_00_6F, 98};
      v42     = '{"v42",     16'd42,   1'b0, 40'h00_00_00_66_5B, 98};

      bus.i_data  = '0;
      bus.i_error = 1'b0;
      bus.i_valid = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_ready", {63'd0, bus.o_ready}, 64'd0);
      checkOutput("rst_ser_data", {63'd0, ser_data}, 64'd0);
      checkOutput("rst_ser_clk", {63'd0, ser_clk}, 64'd0);
      checkOutput("rst_ser_latch", {63'd0, ser_latch}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_release", {63'd0, bus.o_ready}, 64'd1);

      // Table of single frames
      for (int i = 0; i < 10; i++) begin
         runVector(vecs[i]);
      end

      // i_valid is held through a busy frame with new data. The new value waits for the first ready cycle.
      base = edges;
      applyStimulus(16'd1234, 1'b0, 1'b1);
      bus.i_data = 16'd567;
      waitLatch(lat, busy);
      checkOutput("hold_first_latency", 64'(lat), 64'd98);
      checkOutput("hold_first_frame", {24'd0, shreg}, {24'd0, 40'h00_06_5B_4F_66});
      checkOutput("hold_first_edges", 64'(edges - base), 64'd40);
      checkOutput("hold_first_busy_ready", 64'(busy), 64'd0);
      @(negedge clk);
      checkOutput("hold_ready_idle", {63'd0, bus.o_ready}, 64'd1);
      @(negedge clk);
      checkOutput("hold_second_accepted", {63'd0, bus.o_ready}, 64'd0);
      bus.i_valid = 1'b0;
      base = edges;
      waitLatch(lat, busy);
      checkOutput("hold_second_latency", 64'(lat), 64'd98);
      checkOutput("hold_second_frame", {24'd0, shreg}, {24'd0, 40'h00_00_6D_7D_07});
      checkOutput("hold_second_edges", 64'(edges - base), 64'd40);

      // A reset at bit 20 of the shift aborts the frame with no latch pulse
      @(negedge clk);
      lc_before = latch_count;
      base = edges;
      applyStimulus(16'd1234, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         if (edges - base >= 20) break;
         @(negedge clk);
      end
      checkOutput("abort_reached_bit20", 64'(edges - base), 64'd20);
      rst = 1'b1;
      #1;
      checkOutput("abort_ser_data", {63'd0, ser_data}, 64'd0);
      checkOutput("abort_ser_clk", {63'd0, ser_clk}, 64'd0);
      checkOutput("abort_ser_latch", {63'd0, ser_latch}, 64'd0);
      checkOutput("abort_ready", {63'd0, bus.o_ready}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_ready_at_release", {63'd0, bus.o_ready}, 64'd0);
      @(negedge clk);
      checkOutput("abort_ready_one_clk", {63'd0, bus.o_ready}, 64'd1);
      repeat (3) @(negedge clk);
      checkOutput("abort_no_latch", 64'(latch_count), 64'(lc_before));
      runVector(v42);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog in case the design stalls outside the bounded waits
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
